// File: rtl/conv_11_mc.sv
// Multi-channel 1x1 convolution: channel-interleaved stream in, one rounded,
// saturated, optionally ReLU'd weighted sum (plus bias) out per pixel position.
module conv_11_mc #(
  parameter int D          = 299,
  parameter int data_width = 32,
  parameter int N_CH       = 3,
  parameter int FRAC       = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         valid_in,
  input  logic [data_width-1:0]        pxl_in,
  input  logic [N_CH*data_width-1:0]   kernel,
  input  logic [data_width-1:0]        bias,
  input  logic                         relu_en,
  output logic [data_width-1:0]        pxl_out,
  output logic                         valid_out,
  output logic                         frame_done
);
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int PW = (D * D > 1) ? $clog2(D * D) : 1;
  localparam int AW = 2 * data_width + $clog2(N_CH + 1);
  localparam int PRW = 2 * data_width;

  logic [CW-1:0] ch;
  logic [PW-1:0] pix;
  // vld_pipe[0]: sample registered, [1]: product valid, [2]: finished sum ready
  logic [2:0]    vld_pipe;

  logic signed [data_width-1:0] s0_pxl, s0_w;
  logic                         s0_first, s0_last;
  logic signed [PRW-1:0]        prod;
  logic                         s1_first, s1_last;
  logic signed [AW-1:0]         acc;

  logic signed [AW-1:0]         bias_ext, prod_ext, rnd, max_v, min_v;
  logic [data_width-1:0]        res;
  logic                         ch_last;

  assign ch_last  = (ch == CW'(N_CH - 1));
  assign bias_ext = AW'($signed(bias)) <<< FRAC;
  assign prod_ext = AW'(prod);
  assign rnd      = (acc + (AW'(1) <<< (FRAC - 1))) >>> FRAC;
  assign max_v    = (AW'(1) <<< (data_width - 1)) - AW'(1);
  assign min_v    = -(AW'(1) <<< (data_width - 1));

  always_comb begin
    res = rnd[data_width-1:0];
    if (rnd > max_v)      res = max_v[data_width-1:0];
    else if (rnd < min_v) res = min_v[data_width-1:0];
    if (relu_en && res[data_width-1]) res = '0;
  end

  // Stage 0: capture sample with its channel weight and position tags
  always_ff @(posedge clk) begin
    if (reset) begin
      ch          <= '0;
      vld_pipe[0] <= 1'b0;
    end else begin
      vld_pipe[0] <= valid_in;
      if (valid_in) begin
        s0_pxl   <= $signed(pxl_in);
        s0_w     <= $signed(kernel[int'(ch)*data_width +: data_width]);
        s0_first <= (ch == '0);
        s0_last  <= ch_last;
        ch       <= ch_last ? '0 : ch + CW'(1);
      end
    end
  end

  // Stage 1: full-width product
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe[1] <= 1'b0;
    end else begin
      vld_pipe[1] <= vld_pipe[0];
      if (vld_pipe[0]) begin
        prod     <= s0_pxl * s0_w;
        s1_first <= s0_first;
        s1_last  <= s0_last;
      end
    end
  end

  // Stage 2: accumulate; only the last channel hands a sum downstream
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe[2] <= 1'b0;
    end else begin
      vld_pipe[2] <= vld_pipe[1] && s1_last;
      if (vld_pipe[1]) acc <= s1_first ? bias_ext + prod_ext : acc + prod_ext;
    end
  end

  // Stage 3: round/saturate/ReLU, pixel counting
  always_ff @(posedge clk) begin
    if (reset) begin
      pxl_out    <= '0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      pix        <= '0;
    end else begin
      valid_out  <= vld_pipe[2];
      frame_done <= 1'b0;
      if (vld_pipe[2]) begin
        pxl_out <= res;
        if (pix == PW'(D * D - 1)) begin
          pix        <= '0;
          frame_done <= 1'b1;
        end else begin
          pix <= pix + PW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_conv_11_mc.sv
// Scoreboard bench for conv_11_mc: directed pixels push expectations,
// a negedge monitor pops and checks value, frame_done and latency.
module tb_conv_11_mc;
  localparam int D = 4;
  localparam int DW = 32;
  localparam int NC = 3;
  localparam int FR = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              valid_in;
  logic [DW-1:0]     pxl_in;
  logic [NC*DW-1:0]  kernel;
  logic [DW-1:0]     bias;
  logic              relu_en;
  logic [DW-1:0]     pxl_out;
  logic              valid_out, frame_done;

  conv_11_mc #(.D(D), .data_width(DW), .N_CH(NC), .FRAC(FR)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .pxl_in(pxl_in),
    .kernel(kernel), .bias(bias), .relu_en(relu_en),
    .pxl_out(pxl_out), .valid_out(valid_out), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] val;
    logic          fd;
    int            due;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   pix = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: every valid_out must match the oldest expectation
  always @(negedge clk) begin
    if (frame_done && !valid_out) begin
      errors++;
      $display("FAIL frame_done_alone: got frame_done=1 expected 0 with valid_out=0");
    end
    if (valid_out) begin
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: got valid_out=1 pxl_out=0x%08h expected no output", pxl_out);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pxl_out", pxl_out, e.val);
        chk("frame_done", DW'(frame_done), DW'(e.fd));
        chk("latency", DW'(cyc), DW'(e.due));
      end
    end
  end

  task automatic send(input logic [DW-1:0] p, input int gap_max);
    repeat ($urandom_range(0, gap_max)) @(posedge clk);
    #1;
    valid_in = 1'b1;
    pxl_in   = p;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic pixel(input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [DW-1:0] c, input logic [DW-1:0] exp,
                       input int gap_max);
    exp_t e;
    send(a, gap_max);
    send(b, gap_max);
    send(c, gap_max);
    e.val = exp;
    e.fd  = (pix == D * D - 1);
    e.due = cyc + 3;
    q.push_back(e);
    pix = (pix == D * D - 1) ? 0 : pix + 1;
  endtask

  task automatic drain();
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [DW-1:0] w, input logic [DW-1:0] b, input logic r);
    drain();
    kernel  = {w, w, w};
    bias    = b;
    relu_en = r;
  endtask

  initial begin
    reset    = 1'b1;
    valid_in = 1'b0;
    pxl_in   = '0;
    kernel   = '0;
    bias     = '0;
    relu_en  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pxl_out", pxl_out, 32'h0);
    chk("rst_valid_out", DW'(valid_out), 32'h0);
    chk("rst_frame_done", DW'(frame_done), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Basic sums
    set_cfg(32'h0001_0000, 32'h0, 1'b0);
    pixel(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0006_0000, 0);
    set_cfg(32'h0001_0000, 32'h0000_8000, 1'b0);
    pixel(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0006_8000, 0);
    // Rounding half up
    set_cfg(32'h0000_8000, 32'h0, 1'b0);
    pixel(32'h0000_0001, 32'h0, 32'h0, 32'h0000_0001, 0);
    pixel(32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0000_0000, 0);
    // Saturation
    set_cfg(32'h7FFF_0000, 32'h0, 1'b0);
    pixel(32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_FFFF, 0);
    pixel(32'h8001_0000, 32'h8001_0000, 32'h8001_0000, 32'h8000_0000, 0);
    // ReLU off/on
    set_cfg(32'h0001_0000, 32'h0, 1'b0);
    pixel(32'hFFFF_0000, 32'hFFFE_0000, 32'h0000_8000, 32'hFFFD_8000, 0);
    set_cfg(32'h0001_0000, 32'h0, 1'b1);
    pixel(32'hFFFF_0000, 32'hFFFE_0000, 32'h0000_8000, 32'h0000_0000, 0);

    // Reset mid-pixel, with a sample arriving during reset that must be dropped
    set_cfg(32'h0001_0000, 32'h0, 1'b0);
    send(32'h0001_0000, 0);
    send(32'h0001_0000, 0);
    reset    = 1'b1;
    valid_in = 1'b1;
    pxl_in   = 32'h0005_0000;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    valid_in = 1'b0;
    pix      = 0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("abort_no_valid", DW'(valid_out), 32'h0);
    @(posedge clk);
    #1;
    pixel(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0003_0000, 0);

    // Fresh frame: gapped stream of 17 positions, frame_done on the 16th
    drain();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    pix   = 0;
    for (int i = 0; i < 17; i++)
      pixel(DW'(i) << 16, 32'h0001_0000, 32'h0002_0000, DW'(i + 3) << 16, 3);

    for (int t = 0; t < 100 && q.size() != 0; t++) @(posedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d outputs outstanding expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/conv_11_mc.md
# conv_11_mc

Parametrised multi-channel 1x1 (pointwise) convolution, stride 1, padding 0, successor to the single-kernel 1x1 convolution. Accepts a channel-interleaved pixel stream of `N_CH` input planes and produces one output pixel per input pixel position: weighted sum over channels, plus bias, with rounding, saturation and an optional ReLU. It sits in the streaming convolution path between the frame reader and the next layer, and it flags end-of-frame after `D*D` output pixels.

## Interface
- `D`, 299, image side; frame = `D*D` pixel positions
- `data_width`, 32, sample width; signed two's-complement fixed point with `FRAC` fraction bits
- `N_CH`, 3, input channels per pixel position (≥1)
- `FRAC`, 16, fraction bits of pixels, weights, bias and output (1 ≤ `FRAC` < `data_width`)

- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `valid_in`  in  1  `pxl_in` carries a sample this cycle
- `pxl_in`  in  `data_width`  input sample; channel order ch0..ch`N_CH`-1 per position
- `kernel`  in  `N_CH*data_width`  weights; ch k at bits [k*data_width +: data_width]
- `bias`  in  `data_width`  bias added once per output pixel
- `relu_en`  in  1  1 = clamp negative results to 0
- `pxl_out`  out  `data_width`  output pixel
- `valid_out`  out  1  `pxl_out` valid, one-cycle pulse per pixel
- `frame_done`  out  1  pulses together with `valid_out` of pixel `D*D`-1

## Operation
- Channel counter `ch` (0..`N_CH`-1) advances on each `valid_in`; it wraps to 0 after `N_CH`-1. Idle cycles (`valid_in`=0) hold all state.
- Stage 1: `prod = pxl_in * kernel[ch]`, full signed 2·`data_width` product, registered with tags `first` (ch==0) and `last` (ch==`N_CH`-1).
- Stage 2: accumulator, width 2·`data_width`+ceil(log2(`N_CH`+1)). On `first`: `acc = (bias <<< FRAC) + prod`; otherwise `acc = acc + prod`. No overflow is possible inside the accumulator.
- Stage 3, on a `last` result: `r = (acc + 2^(FRAC-1)) >>> FRAC` (round half up, arithmetic shift). Saturate to [-2^(data_width-1), 2^(data_width-1)-1]. If `relu_en` is set and r < 0, r = 0. Register the value into `pxl_out` and pulse `valid_out`.
- Pixel counter (0..`D*D`-1) increments on each `valid_out`. When it holds `D*D`-1, `frame_done`=1 in the same cycle and the counter wraps to 0.
- `kernel` is sampled in stage 1 per channel. `bias` and `relu_en` are sampled when used. All three must be stable from ch0 of a pixel through its output; changing them between pixels is legal.
- Reset: `ch`, pixel counter and all stage valids clear. An in-flight partial pixel is discarded and produces no output. The first `valid_in` after reset is ch0.

## Timing
- Reset values: `pxl_out`=0, `valid_out`=0, `frame_done`=0.
- Latency: `valid_out` rises exactly 3 cycles after the edge that samples the last channel's `valid_in`, independent of gaps between channels.
- Throughput: one sample per cycle sustained; with no gaps, one output every `N_CH` cycles (every cycle when `N_CH`=1).
- `pxl_out` holds its last value while `valid_out`=0.
- If `reset` and `valid_in` are both high in the same cycle, `reset` wins and the sample is dropped.
- `frame_done` is never high without `valid_out`.

## Test plan
- FRAC=16, N_CH=3, weights 1.0 (0x00010000) each, bias 0, inputs 1.0, 2.0, 3.0 back-to-back -> `pxl_out`=0x00060000 with `valid_out` 3 cycles after the ch2 sample; bias 0x00008000 -> 0x00068000.
- Rounding: weights 0.5 (0x00008000), inputs 0x00000001, 0, 0 -> 0x00000001; inputs 0xFFFFFFFF, 0, 0 -> 0x00000000.
- Saturation: weights 0x7FFF0000, inputs 0x7FFF0000 ×3 -> 0x7FFFFFFF; inputs 0x80010000 ×3 -> 0x80000000.
- ReLU: weights 1.0, inputs -1.0, -2.0, 0.5 -> `relu_en`=0 gives 0xFFFD8000; `relu_en`=1 gives 0x00000000.
- Gapped stream plus frame: D=4; random idle cycles between channels; 17 pixel positions -> correct sums, `frame_done` only with the 16th `valid_out`, and the 17th output counts as pixel 0 of the next frame.
- Reset mid-pixel: assert `reset` after ch0 and ch1, then send a full triple 1.0, 1.0, 1.0 with weights 1.0 -> no `valid_out` for the aborted pixel, then `pxl_out`=0x00030000, pixel counter restarted at 0.
